// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control constants: opcode/funct fields, writeback and forwarding
// select encodings, and the hazard controller's FSM states.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_BREAK = 6'h0d;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    WSEL_ALU  = 2'b00,
    WSEL_DMEM = 2'b01,
    WSEL_PC8  = 2'b10
  } wsel_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EXE = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MDU_WAIT = 2'b01,
    ST_HALT     = 2'b10
  } state_e;

  function automatic logic is_mdu_op(input logic [31:0] instr);
    return (instr[31:26] == OP_RTYPE) &&
           (instr[5:0] inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
  endfunction

  function automatic logic is_break_op(input logic [31:0] instr);
    return (instr[31:26] == OP_RTYPE) && (instr[5:0] == FN_BREAK);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_reg_use_decode.sv
// Decodes which source register fields (rs, rt) an ID-stage instruction reads.
import mips_ctrl_pkg::*;

module reg_use_decode (
  input  logic [31:0] instr,
  output logic        rs_used,
  output logic        rt_used
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_fields;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign unused_fields = ^instr[25:6];

  always_comb begin
    rs_used = 1'b0;
    rt_used = 1'b0;
    if (op == OP_RTYPE) begin
      rs_used = !(fn inside {FN_SLL, FN_SRL, FN_SRA});
      rt_used = 1'b1;
    end else begin
      rs_used = !(op inside {OP_J, OP_JAL, OP_LUI});
      rt_used = op inside {OP_BEQ, OP_BNE, OP_SW};
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage MIPS pipeline, including
// the MDU start handshake and break halt.
import mips_ctrl_pkg::*;

module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_instr,
  input  logic [31:0]      exe_instr,
  input  logic             exe_GPR_we,
  input  logic [4:0]       exe_GPR_waddr,
  input  logic [1:0]       exe_GPR_wdata_select,
  input  logic             mem_GPR_we,
  input  logic [4:0]       mem_GPR_waddr,
  input  logic             branch_taken,
  input  logic             mdu_done,
  output logic             pc_ena,
  output logic             if_id_ena,
  output logic             if_id_flush,
  output logic             id_exe_ena,
  output logic             id_exe_bubble,
  output logic             exe_mem_ena,
  output logic             exe_mem_bubble,
  output logic             mem_wb_ena,
  output logic [1:0]       fwd_rs_sel,
  output logic [1:0]       fwd_rt_sel,
  output logic             mdu_start,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e     state, next_state;
  logic       rs_used, rt_used;
  logic [4:0] rs, rt;
  logic       load_use;
  logic       unused_exe;

  assign rs = id_instr[25:21];
  assign rt = id_instr[20:16];
  assign unused_exe = ^exe_instr[25:6];

  reg_use_decode u_reg_use_decode (
    .instr   (id_instr),
    .rs_used (rs_used),
    .rt_used (rt_used)
  );

  function automatic fwd_e fwd_pick(input logic [4:0] src);
    if (src != 5'd0 && exe_GPR_we && exe_GPR_waddr == src &&
        exe_GPR_wdata_select != WSEL_DMEM)
      return FWD_EXE;
    else if (src != 5'd0 && mem_GPR_we && mem_GPR_waddr == src)
      return FWD_MEM;
    else
      return FWD_RF;
  endfunction

  assign load_use = exe_GPR_we && (exe_GPR_wdata_select == WSEL_DMEM) &&
                    (exe_GPR_waddr != 5'd0) &&
                    ((rs_used && exe_GPR_waddr == rs) ||
                     (rt_used && exe_GPR_waddr == rt));

  always_comb begin
    next_state     = state;
    pc_ena         = 1'b0;
    if_id_ena      = 1'b0;
    if_id_flush    = 1'b0;
    id_exe_ena     = 1'b0;
    id_exe_bubble  = 1'b0;
    exe_mem_ena    = 1'b0;
    exe_mem_bubble = 1'b0;
    mem_wb_ena     = 1'b0;
    fwd_rs_sel     = FWD_RF;
    fwd_rt_sel     = FWD_RF;
    mdu_start      = 1'b0;
    halted         = 1'b0;
    if (reset) begin
      fwd_rs_sel = fwd_pick(rs);
      fwd_rt_sel = fwd_pick(rt);
      unique case (state)
        ST_RUN: begin
          if (is_break_op(exe_instr)) begin
            next_state = ST_HALT;
          end else if (is_mdu_op(exe_instr)) begin
            mdu_start      = 1'b1;
            exe_mem_ena    = 1'b1;
            exe_mem_bubble = 1'b1;
            mem_wb_ena     = 1'b1;
            next_state     = ST_MDU_WAIT;
          end else if (load_use) begin
            id_exe_ena    = 1'b1;
            id_exe_bubble = 1'b1;
            exe_mem_ena   = 1'b1;
            mem_wb_ena    = 1'b1;
          end else begin
            pc_ena      = 1'b1;
            if_id_ena   = 1'b1;
            id_exe_ena  = 1'b1;
            exe_mem_ena = 1'b1;
            mem_wb_ena  = 1'b1;
            if_id_flush = branch_taken;
          end
        end
        ST_MDU_WAIT: begin
          exe_mem_ena = 1'b1;
          mem_wb_ena  = 1'b1;
          if (mdu_done) begin
            // Release behaves like a normal advance, so a branch held in ID
            // during the wait still flushes its wrong-path fetch.
            pc_ena      = 1'b1;
            if_id_ena   = 1'b1;
            id_exe_ena  = 1'b1;
            if_id_flush = branch_taken;
            next_state  = ST_RUN;
          end else begin
            exe_mem_bubble = 1'b1;
          end
        end
        ST_HALT: halted = 1'b1;
        default: next_state = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      stall_cnt <= '0;
    end else begin
      state <= next_state;
      if (!pc_ena) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios plus
// randomized traffic checked against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] id_instr = '0, exe_instr = '0;
  logic        exe_GPR_we = 1'b0;
  logic [4:0]  exe_GPR_waddr = '0;
  logic [1:0]  exe_GPR_wdata_select = '0;
  logic        mem_GPR_we = 1'b0;
  logic [4:0]  mem_GPR_waddr = '0;
  logic        branch_taken = 1'b0, mdu_done = 1'b0;
  logic        pc_ena, if_id_ena, if_id_flush, id_exe_ena, id_exe_bubble;
  logic        exe_mem_ena, exe_mem_bubble, mem_wb_ena, mdu_start, halted;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic [31:0] stall_cnt;

  pipeline_hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_instr(id_instr), .exe_instr(exe_instr),
    .exe_GPR_we(exe_GPR_we), .exe_GPR_waddr(exe_GPR_waddr),
    .exe_GPR_wdata_select(exe_GPR_wdata_select), .mem_GPR_we(mem_GPR_we),
    .mem_GPR_waddr(mem_GPR_waddr), .branch_taken(branch_taken),
    .mdu_done(mdu_done), .pc_ena(pc_ena), .if_id_ena(if_id_ena),
    .if_id_flush(if_id_flush), .id_exe_ena(id_exe_ena),
    .id_exe_bubble(id_exe_bubble), .exe_mem_ena(exe_mem_ena),
    .exe_mem_bubble(exe_mem_bubble), .mem_wb_ena(mem_wb_ena),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .mdu_start(mdu_start),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // ctrl = {pc, if_id, flush, id_exe, id_exe_bubble, exe_mem, exe_mem_bubble, mem_wb}
  typedef struct packed {
    logic [7:0]  ctrl;
    logic [3:0]  fwd;
    logic        start;
    logic        halt;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0, n_fail = 0;

  // Reference model: pipeline mode and stall tally
  bit          m_halt = 0, m_wait = 0;
  logic [31:0] m_cnt = '0;

  localparam logic [7:0] ALL_GO  = 8'b1101_0101;
  localparam logic [7:0] FREEZE  = 8'b0000_0111;
  localparam logic [7:0] LU_STALL = 8'b0001_1101;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt);
    return {6'(op), 5'(rs), 5'(rt), 16'h0010};
  endfunction

  function automatic logic [31:0] rand_instr();
    int ops[10] = '{0, 0, 0, 2, 3, 4, 5, 15, 35, 43};
    int fns[10] = '{32, 33, 37, 0, 2, 3, 8, 24, 27, 42};
    int op = ops[$urandom_range(0, 9)];
    if (op == 0)
      return rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   fns[$urandom_range(0, 9)]);
    return itype(op, $urandom_range(0, 7), $urandom_range(0, 7));
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (src == 0) return 2'd0;
    if (exe_GPR_we && exe_GPR_waddr == src && exe_GPR_wdata_select != 2'd1) return 2'd1;
    if (mem_GPR_we && mem_GPR_waddr == src) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit ref_load_use(input logic [31:0] ins);
    int op = int'(ins[31:26]);
    int fn = int'(ins[5:0]);
    bit rs_reads = (op == 0) ? !(fn == 0 || fn == 2 || fn == 3)
                             : !(op == 2 || op == 3 || op == 15);
    bit rt_reads = (op == 0 || op == 4 || op == 5 || op == 43);
    if (!(exe_GPR_we && exe_GPR_wdata_select == 2'd1 && exe_GPR_waddr != 0)) return 0;
    return (rs_reads && ins[25:21] == exe_GPR_waddr) ||
           (rt_reads && ins[20:16] == exe_GPR_waddr);
  endfunction

  task automatic cycle(input logic rst, input logic [31:0] idi, input logic [31:0] exi,
                       input logic we, input int wa, input int ws,
                       input logic mwe, input int mwa, input logic bt, input logic md);
    exp_t e;
    int   exop, exfn;
    @(posedge clk); #1;
    reset = rst; id_instr = idi; exe_instr = exi;
    exe_GPR_we = we; exe_GPR_waddr = 5'(wa); exe_GPR_wdata_select = 2'(ws);
    mem_GPR_we = mwe; mem_GPR_waddr = 5'(mwa); branch_taken = bt; mdu_done = md;
    e = '0;
    exop = int'(exi[31:26]);
    exfn = int'(exi[5:0]);
    if (!rst) begin
      m_halt = 0; m_wait = 0; m_cnt = '0;
    end else begin
      e.cnt = m_cnt;
      e.fwd = {ref_fwd(idi[25:21]), ref_fwd(idi[20:16])};
      if (m_halt) begin
        e.halt = 1'b1;
      end else if (m_wait) begin
        if (md) begin
          e.ctrl = ALL_GO | {2'b00, bt, 5'b0};
          m_wait = 0;
        end else e.ctrl = FREEZE;
      end else if (exop == 0 && exfn == 13) begin
        m_halt = 1;
      end else if (exop == 0 && exfn >= 24 && exfn <= 27) begin
        e.ctrl = FREEZE; e.start = 1'b1; m_wait = 1;
      end else if (ref_load_use(idi)) begin
        e.ctrl = LU_STALL;
      end else begin
        e.ctrl = ALL_GO | {2'b00, bt, 5'b0};
      end
      if (!e.ctrl[7]) m_cnt = m_cnt + 1;
    end
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("ctrl", 32'({pc_ena, if_id_ena, if_id_flush, id_exe_ena, id_exe_bubble,
                         exe_mem_ena, exe_mem_bubble, mem_wb_ena}), 32'(e.ctrl));
      check("fwd", 32'({fwd_rs_sel, fwd_rt_sel}), 32'(e.fwd));
      check("mdu_start", 32'(mdu_start), 32'(e.start));
      check("halted", 32'(halted), 32'(e.halt));
      check("stall_cnt", stall_cnt, e.cnt);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] NOP = 32'h0;

  initial begin
    logic [31:0] add3, or433, lw5, addu6, beq5, mult12;
    add3   = rtype(1, 2, 3, 32);
    or433  = rtype(3, 3, 4, 37);
    lw5    = itype(35, 1, 5);
    addu6  = rtype(5, 2, 6, 33);
    beq5   = itype(4, 5, 0);
    mult12 = rtype(1, 2, 0, 24);

    cycle(0, NOP, NOP, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, or433, add3, 1, 3, 0, 1, 3, 1, 1);

    // Forwarding priority and $0 suppression
    cycle(1, or433, add3, 1, 3, 0, 1, 3, 0, 0);
    cycle(1, or433, NOP,  0, 3, 0, 1, 3, 0, 0);
    cycle(1, or433, NOP,  1, 0, 0, 1, 0, 0, 0);
    cycle(1, or433, add3, 1, 3, 2, 1, 3, 0, 0);
    cycle(1, or433, lw5,  1, 3, 1, 1, 3, 0, 0);

    // Load-use single stall
    cycle(0, NOP, NOP, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, addu6, lw5, 1, 5, 1, 0, 0, 0, 0);
    cycle(1, addu6, NOP, 0, 0, 0, 1, 5, 0, 0);
    cycle(1, NOP,   NOP, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, itype(4, 0, 0), lw5, 1, 0, 1, 0, 0, 1, 0);

    // Load-use beats a taken branch
    cycle(0, NOP, NOP, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, beq5, lw5, 1, 5, 1, 0, 0, 1, 0);
    cycle(1, beq5, NOP, 0, 0, 0, 1, 5, 1, 0);
    cycle(1, NOP,  NOP, 0, 0, 0, 0, 0, 0, 0);

    // MDU: start, five wait cycles, release on done
    cycle(0, NOP, NOP, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, NOP, mult12, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, NOP, mult12, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, NOP, mult12, 0, 0, 0, 0, 0, 0, 1);
    cycle(1, NOP, NOP, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, NOP, NOP, 0, 0, 0, 0, 0, 0, 1);

    // Break halts until reset
    for (int i = 0; i < 100; i++)
      cycle(1, rand_instr(), (i < 2) ? 32'h0000000D : rand_instr(), 0, 0, 0, 0, 0, 0, 0);
    cycle(0, NOP, NOP, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, NOP, NOP, 0, 0, 0, 0, 0, 0, 0);

    // Reset dropped during MDU wait, then a stray done
    cycle(1, NOP, mult12, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, NOP, mult12, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, NOP, mult12, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, NOP, mult12, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, NOP, NOP, 0, 0, 0, 0, 0, 0, 1);
    cycle(1, addu6, NOP, 0, 0, 0, 0, 0, 1, 1);

    // Randomized traffic (break excluded; occasional resets)
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 99) != 0), rand_instr(), rand_instr(),
            1'($urandom), $urandom_range(0, 7), $urandom_range(0, 2),
            1'($urandom), $urandom_range(0, 7),
            1'($urandom), ($urandom_range(0, 3) == 0));
    end

    repeat (2) @(posedge clk);
    check("scoreboard_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
